// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/response encodings, the
// subordinate state enum and byte-lane helpers.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    // Low address bits that must be zero for a naturally aligned transfer.
    function automatic logic [2:0] size_mask(input logic [2:0] hsize);
        case (hsize)
            HSIZE_BYTE: return 3'b000;
            HSIZE_HALF: return 3'b001;
            HSIZE_WORD: return 3'b011;
            default:    return 3'b111;
        endcase
    endfunction

    // Byte strobes for up to 8 lanes; lane_mask = lanes-1 folds the
    // address onto the bus width. Caller slices to its own lane count.
    function automatic logic [7:0] byte_strobe(input logic [2:0] hsize,
                                               input logic [2:0] addr_lo,
                                               input logic [2:0] lane_mask);
        logic [7:0] base;
        logic [2:0] ofs;
        case (hsize)
            HSIZE_BYTE: base = 8'h01;
            HSIZE_HALF: base = 8'h03;
            HSIZE_WORD: base = 8'h0F;
            default:    base = 8'hFF;
        endcase
        ofs = addr_lo & lane_mask;
        return base << ofs;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised RAM with per-byte write enables and an asynchronous
// read port. Kept separate so a vendor macro can be dropped in later.
module ahb_sram_array #(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 1024,
    localparam int STRB_W    = DATA_WIDTH / 8,
    localparam int AW        = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [STRB_W-1:0]     be,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [STRB_W-1:0][7:0] mem [WORDS];

    // Byte-lane write: only strobed lanes of the addressed word change.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (be[i]) mem[addr][i] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite SRAM subordinate: pipelined address/data phases, optional
// wait states on OKAY transfers, two-cycle ERROR for bad accesses.
module ahb_sram_subordinate
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_BYTES   = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFS    = $clog2(STRB_W);
    localparam int WORDS  = MEM_BYTES / STRB_W;
    localparam int WIDX   = $clog2(WORDS);
    localparam int CAP_W  = OFS + WIDX;

    state_t                state;
    logic [3:0]            wait_cnt;
    logic [CAP_W-1:0]      addr_q;
    logic                  write_q;
    logic [2:0]            size_q;

    logic                  accept;
    logic                  bad;
    logic [7:0]            strb_full;
    logic [STRB_W-1:0]     strb;
    logic                  we;
    logic [DATA_WIDTH-1:0] rdata;

    // Address-phase qualification and the out-of-range/size/alignment check.
    always_comb begin
        accept = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
        bad    = (HADDR >= ADDR_WIDTH'(MEM_BYTES))
              || (HSIZE > 3'(OFS))
              || ((HADDR[2:0] & size_mask(HSIZE)) != 3'b000);
    end

    // Transfer FSM; HREADYOUT/HRESP are registered alongside the state.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            wait_cnt  <= 4'd0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            size_q    <= 3'd0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        state     <= S_DATA;
                        HREADYOUT <= 1'b1;
                    end
                    wait_cnt <= wait_cnt - 4'd1;
                end
                S_ERR1: begin
                    state     <= S_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_ERROR;
                end
                // S_IDLE, S_DATA and S_ERR2 all close with HREADYOUT=1,
                // so each may take the next address phase.
                default: begin
                    if (accept) begin
                        addr_q  <= HADDR[CAP_W-1:0];
                        write_q <= HWRITE;
                        size_q  <= HSIZE;
                        if (bad) begin
                            state     <= S_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= HRESP_ERROR;
                        end else if (WAIT_STATES == 0) begin
                            state     <= S_DATA;
                            HREADYOUT <= 1'b1;
                            HRESP     <= HRESP_OKAY;
                        end else begin
                            state     <= S_WAIT;
                            wait_cnt  <= 4'(WAIT_STATES);
                            HREADYOUT <= 1'b0;
                            HRESP     <= HRESP_OKAY;
                        end
                    end else begin
                        state     <= S_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    // Write strobes come from the captured size/address, not the live bus.
    always_comb begin
        strb_full = byte_strobe(size_q, addr_q[2:0], 3'(STRB_W - 1));
        strb      = strb_full[STRB_W-1:0];
        we        = (state == S_DATA) && write_q;
        HRDATA    = (state == S_DATA && !write_q) ? rdata : '0;
    end

    ahb_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORDS      (WORDS)
    ) u_array (
        .clk   (HCLK),
        .we    (we),
        .be    (strb),
        .addr  (addr_q[OFS +: WIDX]),
        .wdata (HWDATA),
        .rdata (rdata)
    );

    // Burst type is accepted but has no effect; upper strobe bits idle on narrow buses.
    logic unused_bits;
    assign unused_bits = ^{HBURST, strb_full};

endmodule

// File: doc/ahb_sram_subordinate.md
Name: ahb_sram_subordinate

Overview:
AHB-Lite subordinate: a word-organised on-chip SRAM with a configurable number of wait states and an AHB two-cycle ERROR response. It sits on the far end of the mainbus driven by the multi-manager block. It is the responder-side model and target used to close the loop on manager and arbiter verification, and it is also synthesisable as a real scratch RAM.

Parameters:
ADDR_WIDTH, 32, width of HADDR
DATA_WIDTH, 32, width of HWDATA/HRDATA; legal values 32 or 64
MEM_BYTES, 4096, memory size in bytes; power of two, multiple of DATA_WIDTH/8
WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase; range 0..15

Ports:
HCLK  input  1  bus clock, rising edge
HRESETn  input  1  asynchronous active-low reset
HSEL  input  1  subordinate select from the address decoder
HADDR  input  ADDR_WIDTH  address-phase address
HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HWRITE  input  1  1 = write
HSIZE  input  3  transfer size, log2 of bytes
HBURST  input  3  burst type; accepted and ignored
HWDATA  input  DATA_WIDTH  write data, valid in data phase
HREADY  input  1  bus-level ready (mux of all HREADYOUT)
HREADYOUT  output  1  this subordinate's ready
HRESP  output  1  0 = OKAY, 1 = ERROR
HRDATA  output  DATA_WIDTH  read data

Behaviour:
- Reset (asynchronous, HRESETn=0): state S_IDLE; HREADYOUT=1, HRESP=0, HRDATA=0; wait counter 0; captured address-phase registers cleared. RAM contents are not reset.
- Address phase is accepted on a rising edge where HSEL=1, HREADY=1 and HTRANS[1]=1. On acceptance, HADDR, HWRITE and HSIZE are registered.
- IDLE, BUSY, or HSEL=0 with HREADY=1: no transfer. The following cycle has HREADYOUT=1 and HRESP=0 (zero-wait OKAY).
- Error check at acceptance. Any one of these causes ERROR, and the RAM is not accessed:
  - HADDR >= MEM_BYTES
  - HSIZE > log2(DATA_WIDTH/8)
  - HADDR not aligned to 2^HSIZE
- States:
  - S_IDLE: no data phase pending.
    - Good accept with WAIT_STATES=0 -> S_DATA.
    - Good accept with WAIT_STATES>0 -> S_WAIT, counter loaded with WAIT_STATES.
    - Bad accept -> S_ERR1.
  - S_WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; at 1 -> S_DATA.
  - S_DATA: HREADYOUT=1, HRESP=0. This is the final data-phase cycle.
    - Write: byte lanes selected by HADDR low bits and HSIZE are written with HWDATA at the closing edge.
    - Read: HRDATA = the full word at the registered word address; unselected lanes also carry RAM data.
    - A new address phase may be accepted in this same cycle (pipelined). Next state is chosen as in S_IDLE; with no accept -> S_IDLE.
  - S_ERR1: HREADYOUT=0, HRESP=1 -> S_ERR2.
  - S_ERR2: HREADYOUT=1, HRESP=1. May accept a new address phase, following S_IDLE rules.
- Throughput: with WAIT_STATES=0, back-to-back transfers complete one per cycle; data-phase latency is 1 cycle after acceptance. Each OKAY transfer occupies WAIT_STATES+1 data-phase cycles.
- HRDATA is 0 in every cycle that is not the S_DATA cycle of a read.
- Read-after-write to the same word, back to back: the read returns the newly written data. The write commits at the edge that starts the read's data phase; the RAM read is asynchronous from the registered address.
- Accept while HREADY=0 never happens; this block ignores HTRANS whenever HREADY=0.
- A manager that cancels (IDLE) during S_WAIT has no effect; the pending data phase completes normally.
- Reset asserted mid data phase: the transfer is aborted, outputs return to reset values, and a partial write is never committed.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS constants: IDLE, BUSY, NONSEQ, SEQ
  - HRESP constants: OKAY, ERROR
  - HSIZE constants
  - the state enum: S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2
  - the byte-strobe function (HSIZE, addr low bits -> DATA_WIDTH/8 strobe vector)
- One sub-module, ahb_sram_array: MEM_BYTES/(DATA_WIDTH/8) words, per-byte write enable, asynchronous read port. It allows a later swap to a vendor macro.

Test Plan:
- Reset, then WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then read 0x10 back to back -> HRDATA=0xDEADBEEF in the read data phase; HREADYOUT stays 1 throughout.
- WAIT_STATES=3: single read of 0x20 -> HREADYOUT=0 for exactly 3 cycles, then 1 with valid data; HRESP=0 throughout.
- Byte write of 0xAA to 0x13 (HSIZE=0) over a word preloaded with 0x11223344 -> word reads 0xAA223344; halfword write of 0x5566 to 0x16 -> upper half of 0x14 becomes 0x5566.
- Read of address MEM_BYTES (0x1000), and halfword access at 0x01 -> each gives cycle 1 HREADYOUT=0/HRESP=1 and cycle 2 HREADYOUT=1/HRESP=1; RAM unchanged.
- Sequence NONSEQ, BUSY, SEQ, IDLE, plus HSEL=0 cycles -> BUSY/IDLE/unselected cycles give zero-wait OKAY; only NONSEQ/SEQ access RAM.
- Assert HRESETn low during an S_WAIT write (WAIT_STATES=2) -> immediately HREADYOUT=1, HRESP=0, HRDATA=0; target word unchanged on later read.
